// File: rtl/alu_iter_if.sv
// alu_iter_if: request/result handshake bundle for alu_iter.
//   i_valid/o_ready    : request handshake (issuer -> ALU)
//   i_alu_control      : 4-bit operation code
//   i_a, i_b           : XLEN-bit operands (i_b low bits double as shift amount)
//   o_valid/i_ready    : result handshake (ALU -> consumer)
//   o_result, o_zero   : registered result and its zero flag
// Signal names keep the i_/o_ prefix as seen from the ALU side.
// The ALU connects through the slave modport; the issuer and consumer use master.
interface alu_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [3:0]      i_alu_control;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_zero;

  modport slave (
    input  i_valid, i_alu_control, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_zero
  );

  modport master (
    output i_valid, i_alu_control, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with valid/ready handshakes on request and result.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : alu_iter_if.slave (request operands/opcode, registered result)
// Non-shift ops finish in one cycle. Shifts by N>0 are done one bit per cycle
// (result valid N+1 cycles after accept) unless ALU_ITER_FAST_SHIFT_EN is
// defined, in which case a barrel shifter gives one-cycle latency for all ops.
module alu_iter #(
  parameter int unsigned XLEN = 32
) (
  input logic       i_clk,
  input logic       i_rst_n,
  alu_iter_if.slave bus
);

  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSlt  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;
  localparam logic [3:0] OpLui  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [ShW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;

  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_shift;

  assign shamt    = bus.i_b[ShW-1:0];
  assign is_shift = (bus.i_alu_control == OpSll) || (bus.i_alu_control == OpSrl) ||
                    (bus.i_alu_control == OpSra);

  // Single-cycle result for the accept edge. In the iterative build a shift
  // only takes this path when its amount is zero, so it simply passes i_a.
  always_comb begin
    alu_res = '0;
    case (bus.i_alu_control)
      OpAdd:  alu_res = bus.i_a + bus.i_b;
      OpSub:  alu_res = bus.i_a - bus.i_b;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.i_a) < $signed(bus.i_b)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, bus.i_a < bus.i_b};
      OpXor:  alu_res = bus.i_a ^ bus.i_b;
      OpOr:   alu_res = bus.i_a | bus.i_b;
      OpAnd:  alu_res = bus.i_a & bus.i_b;
      OpLui:  alu_res = bus.i_b;
`ifdef ALU_ITER_FAST_SHIFT_EN
      OpSll:  alu_res = bus.i_a << shamt;
      OpSrl:  alu_res = bus.i_a >> shamt;
      OpSra:  alu_res = XLEN'($signed(bus.i_a) >>> shamt);
`else
      OpSll, OpSrl, OpSra: alu_res = bus.i_a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifndef ALU_ITER_FAST_SHIFT_EN
  logic [XLEN-1:0] step_res;

  // One-bit shift of the working register, kind chosen by the captured opcode.
  always_comb begin
    step_res = result_q;
    case (op_q)
      OpSll:   step_res = {result_q[XLEN-2:0], 1'b0};
      OpSrl:   step_res = {1'b0, result_q[XLEN-1:1]};
      default: step_res = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          op_d     = bus.i_alu_control;
          result_d = alu_res;
          state_d  = StDone;
`ifndef ALU_ITER_FAST_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            result_d = bus.i_a;
            cnt_d    = shamt;
            state_d  = StShift;
          end
`endif
        end
      end
      StShift: begin
`ifndef ALU_ITER_FAST_SHIFT_EN
        result_d = step_res;
`endif
        cnt_d = cnt_q - ShW'(1);
        // Last step: counter reaches zero on this edge.
        if (cnt_q == ShW'(1)) state_d = StDone;
      end
      StDone: begin
        if (bus.i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    bus.o_ready  = (state_q == StIdle);
    bus.o_valid  = (state_q == StDone);
    bus.o_result = result_q;
    bus.o_zero   = (result_q == '0);
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter (XLEN = 32).
// Stimulus pushes the hand-computed expected result/latency per request;
// a monitor pops and compares on every result handshake.
module tb_alu_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   valid_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_iter_if #(.XLEN(32)) bus ();

  alu_iter #(.XLEN(32)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_ITER_FAST_SHIFT_EN
    return 1;
`else
    if ((c == 4'd2 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Waits for o_ready, presents one request for exactly one accept edge,
  // then scrambles the inputs to prove they were captured.
  task automatic issue(input int id, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.i_valid       = 1'b1;
    bus.i_alu_control = c;
    bus.i_a           = a;
    bus.i_b           = b;
    if (push) sb.push_back('{res: res, zero: (res == 32'd0), lat: exp_lat(c, b),
                             acc: cyc + 1, id: id});
    @(posedge clk);
    #1;
    bus.i_valid       = 1'b0;
    bus.i_alu_control = 4'($urandom);
    bus.i_a           = $urandom;
    bus.i_b           = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !bus.o_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !bus.o_ready) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic [31:0] prev_result = '0;
  logic        exp_idle_next = 1'b0;
  int          first_cyc = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid    = 1'b0;
      exp_idle_next = 1'b0;
    end else begin
      if (exp_idle_next) begin
        check("idle_after_ack", {31'd0, bus.o_ready}, 32'd1);
        exp_idle_next = 1'b0;
      end
      if (bus.o_valid) begin
        valid_cnt++;
        if (!prev_valid) first_cyc = cyc;
        else check("held_result", bus.o_result, prev_result);
        check("ready_low_in_done", {31'd0, bus.o_ready}, 32'd0);
        if (bus.i_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_result", e.id), bus.o_result, e.res);
            check($sformatf("vec%0d_zero", e.id), {31'd0, bus.o_zero}, {31'd0, e.zero});
            check($sformatf("vec%0d_latency", e.id), 32'(first_cyc - e.acc + 1), 32'(e.lat));
          end
          exp_idle_next = 1'b1;
        end
      end
      prev_valid  = bus.o_valid;
      prev_result = bus.o_result;
    end
  end

  // Directed vectors: code, a, b, expected result
  localparam int NV = 18;
  logic [3:0]  v_c [NV] = '{4'h0, 4'h1, 4'h7, 4'h6, 4'hF, 4'h2, 4'h6, 4'h7, 4'h7,
                            4'h4, 4'h3, 4'h5, 4'h8, 4'h9, 4'hA, 4'h1, 4'h2, 4'hB};
  logic [31:0] v_a [NV] = '{32'h7FFFFFFF, 32'h12345678, 32'h80000000, 32'h000000A5,
                            32'h00001234, 32'h00000001, 32'h80000000, 32'h80000000,
                            32'h40000000, 32'hFFFFFFFF, 32'h00000005, 32'h0000F0F0,
                            32'h0000F0F0, 32'h0000F0F0, 32'hDEADBEEF, 32'h00000000,
                            32'h00000001, 32'h00001234};
  logic [31:0] v_b [NV] = '{32'h00000001, 32'h12345678, 32'h0000001F, 32'h00000020,
                            32'h00005678, 32'h00000004, 32'h00000004, 32'h00000004,
                            32'h00000004, 32'h00000000, 32'hFFFFFFFD, 32'h0000FF00,
                            32'h0000FF00, 32'h0000FF00, 32'hABCDE000, 32'h00000001,
                            32'hFFFFFFE3, 32'h00005678};
  logic [31:0] v_r [NV] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h000000A5,
                            32'h00000000, 32'h00000010, 32'h08000000, 32'hF8000000,
                            32'h04000000, 32'h00000000, 32'h00000000, 32'h00000FF0,
                            32'h0000FFF0, 32'h0000F000, 32'hABCDE000, 32'hFFFFFFFF,
                            32'h00000008, 32'h00000000};

  int v0;

  initial begin
    bus.i_valid       = 1'b0;
    bus.i_ready       = 1'b1;
    bus.i_alu_control = 4'h0;
    bus.i_a           = '0;
    bus.i_b           = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, bus.o_ready}, 32'd1);
    check("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset_result", bus.o_result, 32'd0);
    check("reset_zero", {31'd0, bus.o_zero}, 32'd1);

    for (int i = 0; i < NV; i++) issue(i, v_c[i], v_a[i], v_b[i], v_r[i], 1'b1);
    drain();

    // Backpressure: SLT -1 < 0 held for several cycles before acceptance.
    bus.i_ready = 1'b0;
    issue(100, 4'h3, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1);
    repeat (5) @(posedge clk);
    #1 bus.i_ready = 1'b1;
    drain();

    // Reset in the middle of a 20-step SLL: nothing may be delivered.
    v0 = valid_cnt;
    issue(200, 4'h2, 32'h00000001, 32'd20, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_result", bus.o_result, 32'd0);
    check("rst_mid_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, bus.o_valid}, 32'd0);
    repeat (30) @(negedge clk);
    check("rst_mid_no_valid", 32'(valid_cnt - v0), 32'd0);

    issue(300, 4'h0, 32'd2, 32'd3, 32'd5, 1'b1);
    drain();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
